// File: rtl/mem_wb_pkg.sv
// Shared defaults and payload layout for the memory->writeback elastic pipe.
// Module parameters on mem_wb_elastic_pipe override these widths; the
// struct here documents the canonical field order used at every width.
package mem_wb_pkg;

  localparam int unsigned INW_DEF   = 512;
  localparam int unsigned ADDRW_DEF = 32;
  localparam int unsigned REGW_DEF  = 3;
  localparam int unsigned DEPTH_DEF = 2;

  // Payload carried by every stage, MSB first: fft_wr_en, reg_wr_en, wr_reg, addr, data
  typedef struct packed {
    logic                 fft_wr_en;
    logic                 reg_wr_en;
    logic [REGW_DEF-1:0]  wr_reg;
    logic [ADDRW_DEF-1:0] addr;
    logic [INW_DEF-1:0]   data;
  } mwb_payload_t;

endpackage

// File: rtl/mwb_elastic_stage.sv
// One elastic stage: a valid bit plus a payload register.
// Ports:
//   clk, rst_n   clock, async active-low reset (clears valid and payload)
//   flush_i      synchronous kill of the held entry
//   load_i       stage may take a new entry this cycle (empty or popping)
//   valid_i      incoming entry valid (upstream stage or pipe input)
//   payload_i    incoming payload
//   valid_o      stage holds a valid entry
//   payload_o    held payload (don't-care while invalid)
module mwb_elastic_stage
  import mem_wb_pkg::*;
#(
  parameter int unsigned PW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          load_i,
  input  logic          valid_i,
  input  logic [PW-1:0] payload_i,
  output logic          valid_o,
  output logic [PW-1:0] payload_o
);

  logic          valid_q, valid_d;
  logic [PW-1:0] payload_q, payload_d;

  // Next state: payload only moves with a valid entry; flush wins over load
  always_comb begin : next_state
    valid_d   = valid_q;
    payload_d = payload_q;
    if (load_i) begin
      valid_d = valid_i;
    end
    if (load_i && valid_i) begin
      payload_d = payload_i;
    end
    if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/mem_wb_elastic_pipe.sv
// Memory->writeback elastic pipeline: DEPTH valid/ready stages, registered
// occupancy count and a combinational forwarding lookup over in-flight
// register writes. Stage 0 is youngest; stage DEPTH-1 drives the outputs.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      synchronous kill of all in-flight entries
//   valid_in / ready_out       upstream handshake
//   fft_wr_en_in .. data_in    upstream payload
//   valid_out / ready_in       downstream handshake
//   fft_wr_en_out .. data_out  oldest-stage payload
//   fwd_reg_q                  forwarding query register
//   fwd_hit / fwd_data         youngest matching pending register write
//   count                      number of valid stages
module mem_wb_elastic_pipe
  import mem_wb_pkg::*;
#(
  parameter int unsigned INW          = INW_DEF,
  parameter int unsigned ADDRW        = ADDRW_DEF,
  parameter int unsigned REGW         = REGW_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned ZERO_REG_FWD = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic                         fft_wr_en_in,
  input  logic                         reg_wr_en_in,
  input  logic [REGW-1:0]              wr_reg_in,
  input  logic [ADDRW-1:0]             addr_in,
  input  logic [INW-1:0]               data_in,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         fft_wr_en_out,
  output logic                         reg_wr_en_out,
  output logic [REGW-1:0]              wr_reg_out,
  output logic [ADDRW-1:0]             addr_out,
  output logic [INW-1:0]               data_out,
  input  logic [REGW-1:0]              fwd_reg_q,
  output logic                         fwd_hit,
  output logic [INW-1:0]               fwd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Same field order as mwb_payload_t, resized by this instance's parameters
  typedef struct packed {
    logic             fft_wr_en;
    logic             reg_wr_en;
    logic [REGW-1:0]  wr_reg;
    logic [ADDRW-1:0] addr;
    logic [INW-1:0]   data;
  } payload_t;

  logic [DEPTH-1:0] stage_v;
  payload_t         stage_pl [DEPTH];
  logic [DEPTH-1:0] load_ok;
  payload_t         in_pl;

  logic             up_xfer, down_xfer;
  logic [CW-1:0]    count_q, count_d;

  // Incoming payload
  always_comb begin : pack_in
    in_pl           = '0;
    in_pl.fft_wr_en = fft_wr_en_in;
    in_pl.reg_wr_en = reg_wr_en_in;
    in_pl.wr_reg    = wr_reg_in;
    in_pl.addr      = addr_in;
    in_pl.data      = data_in;
  end

  // Ready chain from the oldest stage back: a stage can load if empty or popping
  always_comb begin : ready_chain
    logic down_ok;
    down_ok = ready_in;
    load_ok = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      load_ok[i] = ~stage_v[i] | (stage_v[i] & down_ok);
      down_ok    = load_ok[i];
    end
  end

  // Stage array; each stage takes its predecessor's entry
  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
    logic     src_v;
    payload_t src_pl;

    if (g == 0) begin : g_head
      assign src_v  = valid_in;
      assign src_pl = in_pl;
    end else begin : g_body
      assign src_v  = stage_v[g-1];
      assign src_pl = stage_pl[g-1];
    end

    mwb_elastic_stage #(
      .PW ($bits(payload_t))
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (flush),
      .load_i    (load_ok[g]),
      .valid_i   (src_v),
      .payload_i (src_pl),
      .valid_o   (stage_v[g]),
      .payload_o (stage_pl[g])
    );
  end

  assign ready_out     = load_ok[0];
  assign valid_out     = stage_v[DEPTH-1];
  assign fft_wr_en_out = stage_pl[DEPTH-1].fft_wr_en;
  assign reg_wr_en_out = stage_pl[DEPTH-1].reg_wr_en;
  assign wr_reg_out    = stage_pl[DEPTH-1].wr_reg;
  assign addr_out      = stage_pl[DEPTH-1].addr;
  assign data_out      = stage_pl[DEPTH-1].data;

  assign up_xfer   = valid_in & ready_out;
  assign down_xfer = valid_out & ready_in;

  // Occupancy: tracks popcount of stage valids; flush discards same-cycle transfers
  always_comb begin : count_next
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (up_xfer && !down_xfer) begin
      count_d = count_q + CW'(1);
    end else if (!up_xfer && down_xfer) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : count_reg
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

  // Forwarding: walk oldest to youngest so the youngest match is the last write
  always_comb begin : fwd_scan
    logic query_ok;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    query_ok = (ZERO_REG_FWD != 0) || (fwd_reg_q != '0);
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (query_ok && stage_v[i] && stage_pl[i].reg_wr_en &&
          (stage_pl[i].wr_reg == fwd_reg_q)) begin
        fwd_hit  = 1'b1;
        fwd_data = stage_pl[i].data;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_elastic_pipe.sv
// Self-checking bench for mem_wb_elastic_pipe (DEPTH=2). A second instance
// with ZERO_REG_FWD=1 shares all inputs. The reference model keeps in-flight
// entries as an ordered list with a slot position each.
module tb_mem_wb_elastic_pipe;

  localparam int DEPTH = 2;
  localparam int INW   = 512;
  localparam int ADDRW = 32;
  localparam int REGW  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             valid_in;
  logic             ready_out;
  logic             fft_wr_en_in;
  logic             reg_wr_en_in;
  logic [REGW-1:0]  wr_reg_in;
  logic [ADDRW-1:0] addr_in;
  logic [INW-1:0]   data_in;
  logic             valid_out;
  logic             ready_in;
  logic             fft_wr_en_out;
  logic             reg_wr_en_out;
  logic [REGW-1:0]  wr_reg_out;
  logic [ADDRW-1:0] addr_out;
  logic [INW-1:0]   data_out;
  logic [REGW-1:0]  fwd_reg_q;
  logic             fwd_hit;
  logic [INW-1:0]   fwd_data;
  logic [1:0]       count;

  logic             z_ready_out, z_valid_out, z_fft, z_rwe, z_fwd_hit;
  logic [REGW-1:0]  z_wr_reg;
  logic [ADDRW-1:0] z_addr;
  logic [INW-1:0]   z_data, z_fwd_data;
  logic [1:0]       z_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_wb_elastic_pipe #(
    .INW(INW), .ADDRW(ADDRW), .REGW(REGW), .DEPTH(DEPTH), .ZERO_REG_FWD(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(valid_in), .ready_out(ready_out),
    .fft_wr_en_in(fft_wr_en_in), .reg_wr_en_in(reg_wr_en_in), .wr_reg_in(wr_reg_in),
    .addr_in(addr_in), .data_in(data_in), .valid_out(valid_out), .ready_in(ready_in),
    .fft_wr_en_out(fft_wr_en_out), .reg_wr_en_out(reg_wr_en_out), .wr_reg_out(wr_reg_out),
    .addr_out(addr_out), .data_out(data_out), .fwd_reg_q(fwd_reg_q), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .count(count)
  );

  mem_wb_elastic_pipe #(
    .INW(INW), .ADDRW(ADDRW), .REGW(REGW), .DEPTH(DEPTH), .ZERO_REG_FWD(1)
  ) u_dut_z (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(valid_in), .ready_out(z_ready_out),
    .fft_wr_en_in(fft_wr_en_in), .reg_wr_en_in(reg_wr_en_in), .wr_reg_in(wr_reg_in),
    .addr_in(addr_in), .data_in(data_in), .valid_out(z_valid_out), .ready_in(ready_in),
    .fft_wr_en_out(z_fft), .reg_wr_en_out(z_rwe), .wr_reg_out(z_wr_reg),
    .addr_out(z_addr), .data_out(z_data), .fwd_reg_q(fwd_reg_q), .fwd_hit(z_fwd_hit),
    .fwd_data(z_fwd_data), .count(z_count)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit           fft;
    bit           rwe;
    bit [2:0]     wr_reg;
    bit [31:0]    addr;
    bit [511:0]   data;
    int           pos;   // slot 0 = input side, DEPTH-1 = output
  } ent_t;

  ent_t      mq[$];      // oldest first
  bit [31:0] out_log[$]; // addresses that left the pipe

  // Accept unless all slots are full and nothing leaves downstream
  function automatic bit m_ready();
    return (mq.size() < DEPTH) || (ready_in === 1'b1);
  endfunction

  function automatic bit m_valid();
    return (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
  endfunction

  function automatic void m_fwd(input bit zrf, input bit [2:0] q,
                                output bit h, output bit [511:0] d);
    h = 1'b0;
    d = '0;
    if (!zrf && q == 3'd0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].rwe && mq[i].wr_reg == q) begin
        h = 1'b1;
        d = mq[i].data;
        return;
      end
    end
  endfunction

  // One clock edge: pop, let each entry slide up if any slot above it is free
  // (or the whole column above drains), then append the accepted entry.
  task automatic model_tick();
    ent_t e;
    bit   acc, popd;
    int   n;
    if (rst_n !== 1'b1 || flush === 1'b1) begin
      mq.delete();
      return;
    end
    acc  = (valid_in === 1'b1) && m_ready();
    n    = mq.size();
    popd = m_valid() && (ready_in === 1'b1);
    for (int i = 0; i < n; i++) begin
      if (mq[i].pos < DEPTH - 1 && ((DEPTH - 1 - mq[i].pos) > i || ready_in === 1'b1))
        mq[i].pos = mq[i].pos + 1;
    end
    if (popd) begin
      out_log.push_back(mq[0].addr);
      void'(mq.pop_front());
    end
    if (acc) begin
      e.fft    = fft_wr_en_in;
      e.rwe    = reg_wr_en_in;
      e.wr_reg = wr_reg_in;
      e.addr   = addr_in;
      e.data   = data_in;
      e.pos    = 0;
      mq.push_back(e);
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic set_in(input bit v, input bit fft, input bit rwe, input bit [2:0] r,
                        input bit [31:0] a, input bit [511:0] d);
    valid_in     = v;
    fft_wr_en_in = fft;
    reg_wr_en_in = rwe;
    wr_reg_in    = r;
    addr_in      = a;
    data_in      = d;
  endtask

  function automatic bit [511:0] rand_data();
    bit [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic do_flush();
    flush = 1'b1;
    set_in(0, 0, 0, 0, 0, '0);
    clk_edge();
    flush = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; ready_in = 1'b0; fwd_reg_q = '0;
    set_in(0, 0, 0, 0, 0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || count !== 2'd0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctl: got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", valid_out, count, ready_out);
    end
    checks++;
    if ({fft_wr_en_out, reg_wr_en_out, wr_reg_out, addr_out} !== '0 || data_out !== '0 || fwd_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_payload: got addr=%h wr_reg=%0d hit=%b want all zero", addr_out, wr_reg_out, fwd_hit);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete();
    // stream three entries, then assert reset between edges
    ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 1, 3'(k), 32'h40 + 32'(k), rand_data());
      clk_edge();
    end
    set_in(0, 0, 0, 0, 0, '0);
    ready_in = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || count !== 2'd2 || ready_out !== 1'b0 || addr_out !== 32'h41) begin
      errors++;
      $display("FAIL pre_reset_busy: got v=%b cnt=%0d rdy=%b addr=%h want v=1 cnt=2 rdy=0 addr=41",
               valid_out, count, ready_out, addr_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || count !== 2'd0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", valid_out, count, ready_out);
    end
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete();
    out_log.delete();
  endtask

  task automatic test_stream();
    ready_in = 1'b1;
    out_log.delete();
    for (int k = 0; k < 8; k++) begin
      set_in(1, 1'(k), 1, 3'(k), 32'h10 + 32'(k), rand_data());
      @(negedge clk);
      checks++;
      if (ready_out !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready k=%0d: got %b want 1", k, ready_out);
      end
      checks++;
      if (k >= 2) begin
        if (valid_out !== 1'b1 || addr_out !== 32'h10 + 32'(k - 2) || count !== 2'd2) begin
          errors++;
          $display("FAIL stream_out k=%0d: got v=%b addr=%h cnt=%0d want v=1 addr=%h cnt=2",
                   k, valid_out, addr_out, count, 32'h10 + 32'(k - 2));
        end
      end else if (valid_out !== 1'b0 || count !== 2'(k)) begin
        errors++;
        $display("FAIL stream_fill k=%0d: got v=%b cnt=%0d want v=0 cnt=%0d", k, valid_out, count, k);
      end
      clk_edge();
    end
    set_in(0, 0, 0, 0, 0, '0);
    repeat (3) clk_edge();
    checks++;
    if (out_log.size() != 8) begin
      errors++;
      $display("FAIL stream_count: got %0d entries want 8", out_log.size());
    end
    for (int k = 0; k < 8 && k < out_log.size(); k++) begin
      checks++;
      if (out_log[k] !== 32'h10 + 32'(k)) begin
        errors++;
        $display("FAIL stream_order[%0d]: got %h want %h", k, out_log[k], 32'h10 + 32'(k));
      end
    end
    checks++;
    if (valid_out !== 1'b0 || count !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: got v=%b cnt=%0d want v=0 cnt=0", valid_out, count);
    end
  endtask

  task automatic test_backpressure();
    ready_in = 1'b0;
    out_log.delete();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 0, 0, 32'h20 + 32'(k), rand_data());
      @(negedge clk);
      checks++;
      if (ready_out !== (k < 2)) begin
        errors++;
        $display("FAIL bp_ready k=%0d: got %b want %b", k, ready_out, k < 2);
      end
      clk_edge();
    end
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b0 || count !== 2'd2 || addr_out !== 32'h20) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b cnt=%0d addr=%h want rdy=0 cnt=2 addr=20", ready_out, count, addr_out);
    end
    ready_in = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=1", ready_out, valid_out);
    end
    clk_edge();
    set_in(0, 0, 0, 0, 0, '0);
    @(negedge clk);
    checks++;
    if (count !== 2'd2 || addr_out !== 32'h21) begin
      errors++;
      $display("FAIL bp_pass: got cnt=%0d addr=%h want cnt=2 addr=21", count, addr_out);
    end
    repeat (3) clk_edge();
    checks++;
    if (out_log.size() != 3 || out_log[0] !== 32'h20 || out_log[1] !== 32'h21 || out_log[2] !== 32'h22) begin
      errors++;
      $display("FAIL bp_order: got n=%0d want n=3 order 20,21,22", out_log.size());
    end
  endtask

  task automatic test_flush();
    ready_in = 1'b0;
    out_log.delete();
    for (int k = 0; k < 2; k++) begin
      set_in(1, 0, 1, 3'd1, 32'h30 + 32'(k), rand_data());
      clk_edge();
    end
    set_in(1, 0, 1, 3'd1, 32'h32, rand_data());
    ready_in = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b1 || count !== 2'd2) begin
      errors++;
      $display("FAIL flush_cycle: got rdy=%b cnt=%0d want rdy=1 cnt=2", ready_out, count);
    end
    clk_edge();
    flush = 1'b0;
    set_in(0, 0, 0, 0, 0, '0);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || count !== 2'd0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", valid_out, count, ready_out);
    end
    repeat (3) clk_edge();
    checks++;
    if (out_log.size() != 0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_ghost: got %0d entries out want 0", out_log.size());
    end
  endtask

  task automatic test_forward();
    ready_in = 1'b0;
    set_in(1, 0, 1, 3'd3, 32'h50, 512'hBB); clk_edge();
    set_in(1, 0, 1, 3'd3, 32'h51, 512'hAA); clk_edge();
    set_in(0, 0, 0, 0, 0, '0);
    @(negedge clk);
    fwd_reg_q = 3'd3; #1;
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== 512'hAA) begin
      errors++;
      $display("FAIL fwd_youngest: got hit=%b data=%h want hit=1 data=aa", fwd_hit, fwd_data[31:0]);
    end
    fwd_reg_q = 3'd5; #1;
    checks++;
    if (fwd_hit !== 1'b0 || fwd_data !== '0) begin
      errors++;
      $display("FAIL fwd_miss: got hit=%b data=%h want hit=0 data=0", fwd_hit, fwd_data[31:0]);
    end
    do_flush();
    set_in(1, 0, 0, 3'd3, 32'h52, 512'hBB); clk_edge();
    set_in(1, 0, 0, 3'd3, 32'h53, 512'hAA); clk_edge();
    set_in(0, 0, 0, 0, 0, '0);
    @(negedge clk);
    fwd_reg_q = 3'd3; #1;
    checks++;
    if (fwd_hit !== 1'b0) begin
      errors++;
      $display("FAIL fwd_no_wren: got hit=%b want 0", fwd_hit);
    end
    do_flush();
    set_in(1, 0, 1, 3'd3, 32'h54, 512'hBB); clk_edge();
    set_in(1, 0, 1, 3'd4, 32'h55, 512'hAA); clk_edge();
    set_in(0, 0, 0, 0, 0, '0);
    @(negedge clk);
    fwd_reg_q = 3'd3; #1;
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== 512'hBB) begin
      errors++;
      $display("FAIL fwd_oldest: got hit=%b data=%h want hit=1 data=bb", fwd_hit, fwd_data[31:0]);
    end
    do_flush();
  endtask

  task automatic test_zero_reg();
    ready_in = 1'b0;
    set_in(1, 0, 1, 3'd0, 32'h60, 512'hCC); clk_edge();
    set_in(0, 0, 0, 0, 0, '0);
    @(negedge clk);
    fwd_reg_q = 3'd0; #1;
    checks++;
    if (fwd_hit !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg_off: got hit=%b want 0", fwd_hit);
    end
    checks++;
    if (z_fwd_hit !== 1'b1 || z_fwd_data !== 512'hCC) begin
      errors++;
      $display("FAIL zero_reg_on: got hit=%b data=%h want hit=1 data=cc", z_fwd_hit, z_fwd_data[31:0]);
    end
    do_flush();
  endtask

  task automatic test_random();
    bit         h;
    bit [511:0] d;
    bit         ev;
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), $urandom(), rand_data());
      ready_in  = $urandom_range(0, 99) < 60;
      flush     = $urandom_range(0, 99) < 3;
      fwd_reg_q = 3'($urandom_range(0, 7));
      @(negedge clk);
      ev = m_valid();
      checks++;
      if (ready_out !== m_ready() || z_ready_out !== m_ready()) begin
        errors++;
        $display("FAIL rnd_ready n=%0d: got %b/%b want %b", n, ready_out, z_ready_out, m_ready());
      end
      checks++;
      if (valid_out !== ev || z_valid_out !== ev || count !== 2'(mq.size()) || z_count !== 2'(mq.size())) begin
        errors++;
        $display("FAIL rnd_state n=%0d: got v=%b cnt=%0d want v=%b cnt=%0d", n, valid_out, count, ev, mq.size());
      end
      if (ev) begin
        checks++;
        if ({fft_wr_en_out, reg_wr_en_out, wr_reg_out, addr_out} !== {mq[0].fft, mq[0].rwe, mq[0].wr_reg, mq[0].addr} ||
            {z_fft, z_rwe, z_wr_reg, z_addr} !== {mq[0].fft, mq[0].rwe, mq[0].wr_reg, mq[0].addr}) begin
          errors++;
          $display("FAIL rnd_ctl n=%0d: got addr=%h reg=%0d want addr=%h reg=%0d",
                   n, addr_out, wr_reg_out, mq[0].addr, mq[0].wr_reg);
        end
        checks++;
        if (data_out !== mq[0].data || z_data !== mq[0].data) begin
          errors++;
          $display("FAIL rnd_data n=%0d: got %h want %h", n, data_out[63:0], mq[0].data[63:0]);
        end
      end
      m_fwd(1'b0, fwd_reg_q, h, d);
      checks++;
      if (fwd_hit !== h || fwd_data !== d) begin
        errors++;
        $display("FAIL rnd_fwd n=%0d q=%0d: got hit=%b data=%h want hit=%b data=%h",
                 n, fwd_reg_q, fwd_hit, fwd_data[63:0], h, d[63:0]);
      end
      m_fwd(1'b1, fwd_reg_q, h, d);
      checks++;
      if (z_fwd_hit !== h || z_fwd_data !== d) begin
        errors++;
        $display("FAIL rnd_fwd_z n=%0d q=%0d: got hit=%b data=%h want hit=%b data=%h",
                 n, fwd_reg_q, z_fwd_hit, z_fwd_data[63:0], h, d[63:0]);
      end
      clk_edge();
    end
    flush = 1'b0;
    set_in(0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_forward();
    test_zero_reg();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
